// File: rtl/axi4l_pkg.sv
// Shared constants and state types for the AXI4-Lite register bank.
package axi4l_pkg;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [1:0]  RESP_SLVERR      = 2'b10;
  localparam logic [31:0] DEFAULT_ID_VALUE = 32'hA5A5_0001;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

endpackage

// File: rtl/axi4l_regs_decode.sv
// Byte address to register index and in-range flag. The two byte-offset
// bits are don't-care; every bit above the index must be zero.
module axi4l_regs_decode
  import axi4l_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 4
) (
  input  logic [ADDR_WIDTH-1:0]       addr,
  output logic [$clog2(NUM_REGS)-1:0] idx,
  output logic                        in_range
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic unused_lsbs;

  assign idx         = addr[2+IDX_W-1:2];
  assign unused_lsbs = ^addr[1:0];

  generate
    if (ADDR_WIDTH > 2 + IDX_W) begin : g_hi
      assign in_range = (addr[ADDR_WIDTH-1:2+IDX_W] == '0);
    end else begin : g_nohi
      assign in_range = 1'b1;
    end
  endgenerate

endmodule

// File: rtl/axi4l_regs.sv
// AXI4-Lite slave register bank: register 0 is a read-only ID word, the rest
// are byte-strobed R/W registers. Read and write channels are independent,
// each with a single outstanding transaction.
module axi4l_regs
  import axi4l_pkg::*;
#(
  parameter int                 ADDR_WIDTH = 32,
  parameter int                 DATA_WIDTH = 32,
  parameter int                 NUM_REGS   = 4,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = DEFAULT_ID_VALUE
) (
  input  logic                    clk,
  input  logic                    arstn,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]              awprot,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]              arprot,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_WIDTH / 8;

  // Merge new data into the old word, one byte lane per strobe bit.
  function automatic logic [DATA_WIDTH-1:0] apply_wstrb(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] res;
    for (int b = 0; b < STRB_W; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  wr_state_e wr_state, wr_state_nxt;
  rd_state_e rd_state, rd_state_nxt;

  logic                  rst_done;
  logic                  aw_done, w_done;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [1:0]            bresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [IDX_W-1:0] widx, ridx;
  logic             w_in_range, r_in_range;
  logic             aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_commit;
  logic             unused_prot;

  assign unused_prot = ^{awprot, arprot};

  axi4l_regs_decode #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)) u_wdec (
    .addr     (waddr_q),
    .idx      (widx),
    .in_range (w_in_range)
  );

  axi4l_regs_decode #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)) u_rdec (
    .addr     (araddr),
    .idx      (ridx),
    .in_range (r_in_range)
  );

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid  && wready;
  assign b_hs      = bvalid  && bready;
  assign ar_hs     = arvalid && arready;
  assign r_hs      = rvalid  && rready;
  assign wr_commit = (wr_state == W_IDLE) && aw_done && w_done;

  // Holds all ready outputs low while reset is asserted and for the first edge after.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) rst_done <= 1'b0;
    else        rst_done <= 1'b1;
  end

  // Write FSM state register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) wr_state <= W_IDLE;
    else        wr_state <= wr_state_nxt;
  end

  // Write FSM next state: respond once both beats are in, idle after B handshake.
  always_comb begin
    wr_state_nxt = wr_state;
    unique case (wr_state)
      W_IDLE: if (wr_commit) wr_state_nxt = W_RESP;
      W_RESP: if (b_hs)      wr_state_nxt = W_IDLE;
      default:               wr_state_nxt = W_IDLE;
    endcase
  end

  // Write FSM outputs: each ready stays up only until its own beat is captured.
  always_comb begin
    awready = rst_done && (wr_state == W_IDLE) && !aw_done;
    wready  = rst_done && (wr_state == W_IDLE) && !w_done;
    bvalid  = (wr_state == W_RESP);
  end

  // Beat-captured flags, cleared when the write commits.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (wr_commit) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  // Address/data/strobe latched on their own handshake edge.
  always_ff @(posedge clk) begin
    if (aw_hs) waddr_q <= awaddr;
    if (w_hs) begin
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

  // Register file update and write response, both on the commit edge.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      bresp_q <= RESP_OKAY;
    end else if (wr_commit) begin
      bresp_q <= w_in_range ? RESP_OKAY : RESP_SLVERR;
      if (w_in_range && (widx != '0)) begin
        regs[widx] <= apply_wstrb(regs[widx], wdata_q, wstrb_q);
      end
    end
  end

  assign bresp = bresp_q;

  // Read FSM state register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) rd_state <= R_IDLE;
    else        rd_state <= rd_state_nxt;
  end

  // Read FSM next state.
  always_comb begin
    rd_state_nxt = rd_state;
    unique case (rd_state)
      R_IDLE:  if (ar_hs) rd_state_nxt = R_DATA;
      R_DATA:  if (r_hs)  rd_state_nxt = R_IDLE;
      default:            rd_state_nxt = R_IDLE;
    endcase
  end

  // Read FSM outputs.
  always_comb begin
    arready = rst_done && (rd_state == R_IDLE);
    rvalid  = (rd_state == R_DATA);
  end

  // Read data captured on the AR handshake; sees the register value before any same-edge write.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      if (!r_in_range) begin
        rdata_q <= '0;
        rresp_q <= RESP_SLVERR;
      end else begin
        rdata_q <= (ridx == '0) ? ID_VALUE : regs[ridx];
        rresp_q <= RESP_OKAY;
      end
    end
  end

  assign rdata = rdata_q;
  assign rresp = rresp_q;

endmodule

// File: tb/tb_axi4l_regs.sv
// Randomised scoreboard bench for the AXI4-Lite register bank.
module tb_axi4l_regs;

  localparam int          NREGS  = 4;
  localparam logic [31:0] ID_VAL = 32'hA5A5_0001;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] model [NREGS];
  logic [33:0] rd_q [$];
  logic [1:0]  wr_q [$];

  always #5 clk = ~clk;

  axi4l_regs dut (
    .clk(clk), .arstn(arstn),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_in_range(input logic [31:0] addr);
    return (addr / 4) < NREGS;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] addr);
    if (!m_in_range(addr)) return 32'h0;
    if (addr / 4 == 0)     return ID_VAL;
    return model[addr / 4];
  endfunction

  task automatic m_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int k;
    logic [31:0] v;
    if (!m_in_range(addr) || addr / 4 == 0) return;
    k = addr / 4;
    v = model[k];
    for (int b = 0; b < 4; b++) if (strb[b]) v[8*b +: 8] = data[8*b +: 8];
    model[k] = v;
  endtask

  task automatic m_reset();
    for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    logic [33:0] er;
    logic [1:0]  eb;
    if (rvalid && rready) begin
      if (rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
      else begin
        er = rd_q.pop_front();
        check("rd_data", rdata, er[33:2]);
        check("rd_resp", {30'd0, rresp}, {30'd0, er[1:0]});
      end
    end
    if (bvalid && bready) begin
      if (wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
      else begin
        eb = wr_q.pop_front();
        check("wr_resp", {30'd0, bresp}, {30'd0, eb});
      end
    end
  end

  task automatic do_read(input logic [31:0] addr, input int r_dly, input int pre_dly,
                         input bit use_exp, input logic [31:0] exp_d);
    logic [31:0] e;
    logic [1:0]  er;
    int cyc;
    bit hs;
    e  = use_exp ? exp_d : m_read(addr);
    er = m_in_range(addr) ? OKAY : SLVERR;
    rd_q.push_back({e, er});
    repeat (pre_dly) begin @(posedge clk); #1; end
    araddr  = addr;
    arvalid = 1'b1;
    cyc = 0;
    hs  = 1'b0;
    while (!hs && cyc < 50) begin
      @(negedge clk);
      hs = arready;
      cyc++;
    end
    check("ar_handshake", {31'd0, hs}, 32'd1);
    check("rvalid_pre", {31'd0, rvalid}, 32'd0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("rvalid_lat", {31'd0, rvalid}, 32'd1);
    repeat (r_dly) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rvalid_hold", {31'd0, rvalid}, 32'd1);
      check("rdata_hold", rdata, e);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    check("rvalid_drop", {31'd0, rvalid}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0] eb;
    bit aw_ok, w_ok, aw_now, w_now;
    int cyc;
    eb = m_in_range(addr) ? OKAY : SLVERR;
    wr_q.push_back(eb);
    m_write(addr, data, strb);
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    aw_ok = 1'b0;
    w_ok  = 1'b0;
    cyc   = 0;
    while (!(aw_ok && w_ok) && cyc < 60) begin
      awvalid = !aw_ok && (cyc >= aw_dly);
      wvalid  = !w_ok  && (cyc >= w_dly);
      @(negedge clk);
      if (w_ok)  check("wready_after_beat", {31'd0, wready}, 32'd0);
      if (aw_ok) check("awready_after_beat", {31'd0, awready}, 32'd0);
      aw_now = awvalid && awready;
      w_now  = wvalid && wready;
      @(posedge clk); #1;
      aw_ok = aw_ok | aw_now;
      w_ok  = w_ok | w_now;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("wr_handshake", {30'd0, aw_ok, w_ok}, 32'd3);
    @(negedge clk);
    check("bvalid_early", {31'd0, bvalid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bvalid_lat", {31'd0, bvalid}, 32'd1);
    repeat (b_dly) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bvalid_hold", {31'd0, bvalid}, 32'd1);
      check("bresp_hold", {30'd0, bresp}, {30'd0, eb});
    end
    @(posedge clk); #1;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    check("bvalid_drop", {31'd0, bvalid}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_v, a;
    int hs_cyc;
    m_reset();

    // Reset state
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready",  {31'd0, wready},  32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_bvalid",  {31'd0, bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_resps",   {28'd0, bresp, rresp}, 32'd0);
    check("rst_rdata",   rdata, 32'd0);
    @(posedge clk); #1;
    arstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("post_rst_ready", {29'd0, awready, wready, arready}, 32'd7);
    @(posedge clk); #1;

    // ID word at every byte offset
    for (int i = 0; i < 4; i++) do_read(i, 0, 0, 1'b0, 32'h0);

    // Full and partial strobe writes
    do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_write(32'h4, 32'h0000_0012, 4'h1, 0, 0, 0);
    do_read(32'h4, 0, 0, 1'b1, 32'hDEADBE12);
    do_write(32'h0, 32'h1234_5678, 4'hF, 0, 0, 0);
    do_read(32'h0, 1, 0, 1'b1, ID_VAL);

    // W leads AW by 3 cycles, slow bready
    do_write(32'h8, 32'h0BAD_F00D, 4'hF, 3, 0, 5);
    do_read(32'h8, 0, 0, 1'b1, 32'h0BAD_F00D);
    do_write(32'hC, 32'h5555_AAAA, 4'hA, 0, 2, 1);
    do_read(32'hC, 2, 0, 1'b0, 32'h0);

    // Out of range
    do_read(32'h10, 0, 0, 1'b0, 32'h0);
    do_write(32'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    do_write(32'h8000_0004, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    for (int i = 1; i < NREGS; i++) do_read(i * 4, 0, 0, 1'b0, 32'h0);

    // Read and write of the same register on the same edge
    old_v = m_read(32'h4);
    fork
      do_write(32'h4, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
      do_read(32'h4, 0, 1, 1'b1, old_v);
    join
    do_read(32'h4, 0, 0, 1'b1, 32'hCAFE_F00D);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2, 3: a = $urandom_range(0, NREGS * 4 - 1);
        4:          a = 32'h10 + $urandom_range(0, 15);
        default:    a = {1'b1, 27'($urandom), 4'($urandom_range(0, 15))};
      endcase
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 3), 0, 1'b0, 32'h0);
    end

    // Reset while a read response is pending
    do_write(32'h4, 32'h1357_9BDF, 4'hF, 0, 0, 0);
    araddr  = 32'h4;
    arvalid = 1'b1;
    hs_cyc  = 0;
    @(negedge clk);
    while (!arready && hs_cyc < 50) begin @(negedge clk); hs_cyc++; end
    check("mid_ar_handshake", {31'd0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("mid_rvalid", {31'd0, rvalid}, 32'd1);
    check("mid_rdata", rdata, 32'h1357_9BDF);
    #2;
    arstn = 1'b0;
    #1;
    check("async_rvalid", {31'd0, rvalid}, 32'd0);
    check("async_arready", {31'd0, arready}, 32'd0);
    check("async_rdata", rdata, 32'd0);
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    arstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_read(32'h4, 0, 0, 1'b1, 32'h0);

    repeat (3) @(posedge clk);
    check("rd_queue_empty", rd_q.size(), 32'd0);
    check("wr_queue_empty", wr_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
